// File: rtl/seg7_capture.sv
// ============================================================================
// Module      : seg7_capture
// Description : Seven-segment readback decoder. Synchronises an active-low
//               segment bus and waits for it to settle. Each distinct stable
//               pattern is decoded to a hex digit, a dash flag or an illegal
//               flag. The result goes out through a one-entry valid/ready
//               buffer.
// Options     : SEG7_DP_CHECK_EN - when defined, the decimal point (bit 7)
//               takes part in synchronisation and compares, and must be off
//               (1) for a legal decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] digit,
  output logic       is_dash,
  output logic       bad_pattern,
  output logic       overrun
);

`ifdef SEG7_DP_CHECK_EN
  localparam int c_W = 8;
`else
  localparam int c_W = 7;
  // The decimal point plays no part in this build.
  logic w_unused_dp;
  assign w_unused_dp = seg_in[7];
`endif

  localparam logic [7:0] c_CNT_MAX = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_EMIT   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic [c_W-1:0] r_s1, r_s2, r_cand, r_last;
  logic [7:0]     r_cnt;
  logic           r_reported;
  state_t         r_state, w_state_nxt;

  logic           w_same, w_stable, w_new, w_emit;
  logic [3:0]     w_digit;
  logic           w_dash, w_bad;

  assign w_same   = (r_s2 == r_cand);
  assign w_stable = w_same && (r_cnt == c_CNT_MAX);
  assign w_new    = !r_reported || (r_cand != r_last);
  assign w_emit   = (r_state == ST_SETTLE) && w_stable && w_new;

  // Two-flop synchroniser; idle (all segments off) out of reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= seg_in[c_W-1:0];
      r_s2 <= r_s1;
    end
  end

  // Settle counter: restart on any change, saturate once stable; remember the last emitted pattern.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cand     <= '0;
      r_cnt      <= '0;
      r_last     <= '0;
      r_reported <= 1'b0;
    end else begin
      if (!w_same) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt < c_CNT_MAX) begin
        r_cnt <= r_cnt + 8'd1;
      end
      // A dropped result still counts as reported.
      if (w_emit) begin
        r_last     <= r_cand;
        r_reported <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_SETTLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: emit new stable patterns, park on already-reported ones.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SETTLE: begin
        if (w_stable) w_state_nxt = w_new ? ST_EMIT : ST_HOLD;
      end
      // A change seen during the emit cycle goes straight back to settling,
      // so it cannot be lost once the candidate register has absorbed it.
      ST_EMIT:  w_state_nxt = w_same ? ST_HOLD : ST_SETTLE;
      ST_HOLD:  if (!w_same) w_state_nxt = ST_SETTLE;
      default:  w_state_nxt = ST_SETTLE;
    endcase
  end

  // Decode the settled candidate into digit / dash / illegal.
  always_comb begin
    w_digit = 4'h0;
    w_dash  = 1'b0;
    w_bad   = 1'b0;
    case (r_cand[6:0])
      7'h40: w_digit = 4'h0;
      7'h79: w_digit = 4'h1;
      7'h24: w_digit = 4'h2;
      7'h30: w_digit = 4'h3;
      7'h19: w_digit = 4'h4;
      7'h12: w_digit = 4'h5;
      7'h02: w_digit = 4'h6;
      7'h78: w_digit = 4'h7;
      7'h00: w_digit = 4'h8;
      7'h10: w_digit = 4'h9;
      7'h08: w_digit = 4'hA;
      7'h03: w_digit = 4'hB;
      7'h46: w_digit = 4'hC;
      7'h21: w_digit = 4'hD;
      7'h06: w_digit = 4'hE;
      7'h0E: w_digit = 4'hF;
      7'h3F: w_dash  = 1'b1;
      default: w_bad = 1'b1;
    endcase
`ifdef SEG7_DP_CHECK_EN
    // A lit decimal point makes the whole pattern illegal.
    if (!r_cand[7]) begin
      w_digit = 4'h0;
      w_dash  = 1'b0;
      w_bad   = 1'b1;
    end
`endif
  end

  // One-entry output buffer: load when free or being drained, otherwise drop and flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid   <= 1'b0;
      digit       <= 4'h0;
      is_dash     <= 1'b0;
      bad_pattern <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_emit && (!out_valid || out_ready)) begin
        out_valid   <= 1'b1;
        digit       <= w_digit;
        is_dash     <= w_dash;
        bad_pattern <= w_bad;
      end else if (w_emit) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture.sv
// ============================================================================
// Module      : tb_seg7_capture
// Description : Directed self-checking bench for seg7_capture
//               (STABLE_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_capture;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] seg_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] digit;
  logic       is_dash;
  logic       bad_pattern;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  // results captured by run()
  int         nres;
  int         novr;
  logic [3:0] r_dig;
  logic       r_dash;
  logic       r_bad;

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .seg_in(seg_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .digit(digit), .is_dash(is_dash), .bad_pattern(bad_pattern),
    .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Advance n edges, sampling 1 ns after each; a handshake counts as a result.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      if (out_valid && out_ready) begin
        nres++;
        r_dig  = digit;
        r_dash = is_dash;
        r_bad  = bad_pattern;
      end
      if (overrun) novr++;
    end
  endtask

  task automatic clr();
    nres = 0; novr = 0; r_dig = 4'hx; r_dash = 1'bx; r_bad = 1'bx;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; seg_in = 8'hC0; out_ready = 1'b1;
    #23;
    total++;
    if ({out_valid, digit, is_dash, bad_pattern, overrun} !== 8'h00) begin
      bad++; $display("FAIL reset_outputs got=%h exp=00", {out_valid, digit, is_dash, bad_pattern, overrun});
    end
    @(negedge Clk); Reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clk); #1;
      total++;
      if (out_valid !== (k == 7)) begin
        bad++; $display("FAIL latency_valid edge=%0d got=%b exp=%b", k, out_valid, (k == 7));
      end
      if (k == 7) begin
        total++;
        if ({digit, is_dash, bad_pattern} !== 6'h00) begin
          bad++; $display("FAIL first_result got=%h exp=00", {digit, is_dash, bad_pattern});
        end
      end
    end
  endtask

  task automatic test_bad();
    clr(); seg_in = 8'hFF; run(10);
    total++;
    if (nres !== 1 || r_bad !== 1'b1 || r_dig !== 4'h0 || r_dash !== 1'b0) begin
      bad++; $display("FAIL bad_ff got n=%0d bad=%b dig=%h dash=%b exp n=1 bad=1 dig=0 dash=0", nres, r_bad, r_dig, r_dash);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] codes [17];
    codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hBF};
    for (int i = 0; i < 17; i++) begin
      clr(); seg_in = codes[i]; run(8);
      total++;
      if (nres !== 1 || r_bad !== 1'b0 || r_dash !== (i == 16) || r_dig !== ((i == 16) ? 4'h0 : 4'(i))) begin
        bad++; $display("FAIL seq_%0d got n=%0d dig=%h dash=%b bad=%b", i, nres, r_dig, r_dash, r_bad);
      end
    end
  endtask

  task automatic test_glitch();
    clr();
    seg_in = 8'hF9; run(10);
    seg_in = 8'hA4; run(2);
    seg_in = 8'hF9; run(12);
    total++;
    if (nres !== 1 || r_dig !== 4'h1 || r_bad !== 1'b0) begin
      bad++; $display("FAIL glitch got n=%0d dig=%h bad=%b exp n=1 dig=1 bad=0", nres, r_dig, r_bad);
    end
  endtask

  task automatic test_dp();
    clr(); seg_in = 8'h40; run(10);
    total++;
`ifdef SEG7_DP_CHECK_EN
    if (nres !== 1 || r_bad !== 1'b1 || r_dig !== 4'h0) begin
      bad++; $display("FAIL dp_40 got n=%0d bad=%b dig=%h exp n=1 bad=1 dig=0", nres, r_bad, r_dig);
    end
`else
    if (nres !== 1 || r_bad !== 1'b0 || r_dig !== 4'h0 || r_dash !== 1'b0) begin
      bad++; $display("FAIL dp_40 got n=%0d bad=%b dig=%h exp n=1 bad=0 dig=0", nres, r_bad, r_dig);
    end
`endif
  endtask

  task automatic test_overrun();
    clr(); out_ready = 1'b0;
    seg_in = 8'hB0; run(10);
    total++;
    if (out_valid !== 1'b1 || digit !== 4'h3 || novr !== 0) begin
      bad++; $display("FAIL ovr_first got v=%b dig=%h ovr=%0d exp v=1 dig=3 ovr=0", out_valid, digit, novr);
    end
    seg_in = 8'h99; run(10);
    total++;
    if (novr !== 1) begin
      bad++; $display("FAIL ovr_pulse got=%0d exp=1", novr);
    end
    total++;
    if (out_valid !== 1'b1 || digit !== 4'h3) begin
      bad++; $display("FAIL ovr_held got v=%b dig=%h exp v=1 dig=3", out_valid, digit);
    end
    out_ready = 1'b1;
    clr(); run(1);
    total++;
    if (nres !== 0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ovr_accept got v=%b exp v=0", out_valid);
    end
    run(4);
    total++;
    if (nres !== 0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ovr_nomore got n=%0d exp=0", nres);
    end
  endtask

  task automatic test_reset_mid();
    clr(); out_ready = 1'b0;
    seg_in = 8'hF9; run(10);
    total++;
    if (out_valid !== 1'b1 || digit !== 4'h1) begin
      bad++; $display("FAIL mid_pre got v=%b dig=%h exp v=1 dig=1", out_valid, digit);
    end
    seg_in = 8'hB0; run(3);
    #2 Reset_n = 1'b0;
    #1;
    total++;
    if ({out_valid, digit, is_dash, bad_pattern, overrun} !== 8'h00) begin
      bad++; $display("FAIL mid_async got=%h exp=00", {out_valid, digit, is_dash, bad_pattern, overrun});
    end
    @(negedge Clk); Reset_n = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge Clk); #1;
      total++;
      if (out_valid !== (k == 7) || (k == 7 && digit !== 4'h3)) begin
        bad++; $display("FAIL mid_after edge=%0d got v=%b dig=%h exp v=%b dig=3", k, out_valid, digit, (k == 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_bad();
    test_sequence();
    test_glitch();
    test_dp();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
